// File: rtl/uart_tx_engine_if.sv
// Byte handshake between the TX FIFO (master) and the UART serialiser (slave).
interface uart_tx_engine_if #(
  parameter int MAX_DATA_W = 9
);
  logic                  tx_valid;
  logic                  tx_ready;
  logic [MAX_DATA_W-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// Parametrised UART serialiser: baud divider, valid/ready word intake, 5..MAX_DATA_W data bits,
// five parity modes, 1/1.5/2 stop bits, break control and a registered serial output.
module uart_tx_engine #(
  parameter int MAX_DATA_W = 9,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       dlen,
  input  logic [2:0]       par_mode,
  input  logic [1:0]       stop_mode,
  input  logic             bc,
  uart_tx_engine_if.slave  tx,
  output logic             tx_busy,
  output logic             txfinished,
  output logic             sout
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int TICK_W = $clog2(2 * OVERSAMPLE);
  localparam logic [TICK_W-1:0] LAST_BIT      = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] LAST_STOP_1P5 = TICK_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_STOP_2   = TICK_W'(2 * OVERSAMPLE - 1);

  state_t                state, state_next;
  logic [DIV_W-1:0]      baud_cnt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [3:0]            bit_idx, idx_next;
  logic [MAX_DATA_W-1:0] data_q;
  logic [3:0]            dlen_q;
  logic                  par_en_q, par_bit_q;
  logic [1:0]            stop_q;

  logic [DIV_W-1:0]      div_m1;
  logic [3:0]            dlen_c;
  logic [MAX_DATA_W-1:0] data_mask;
  logic                  par_en_c, par_bit_c;
  logic [TICK_W-1:0]     last_tick;
  logic                  tick, bit_end, stop_end, accept, line_next;

  function automatic logic [3:0] clamp_dlen(input logic [3:0] d);
    if (d < 4'd5)                    return 4'd5;
    else if (d > 4'(MAX_DATA_W))     return 4'(MAX_DATA_W);
    else                             return d;
  endfunction

  // A divisor of zero behaves as one, so the reload value saturates at zero.
  assign div_m1 = (div == '0) ? '0 : div - DIV_W'(1);
  assign dlen_c = clamp_dlen(dlen);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    data_mask = '0;
    par_en_c  = 1'b0;
    par_bit_c = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) data_mask[i] = (i < int'(dlen_c));
    unique case (par_mode)
      3'b001:  begin par_en_c = 1'b1; par_bit_c = ~^(tx.tx_data & data_mask); end
      3'b010:  begin par_en_c = 1'b1; par_bit_c =  ^(tx.tx_data & data_mask); end
      3'b011:  begin par_en_c = 1'b1; par_bit_c = 1'b1; end
      3'b100:  begin par_en_c = 1'b1; par_bit_c = 1'b0; end
      default: begin par_en_c = 1'b0; par_bit_c = 1'b0; end
    endcase
  end

  always_comb begin
    last_tick = LAST_BIT;
    if (state == STOP) begin
      unique case (stop_q)
        2'b00:   last_tick = LAST_BIT;
        2'b01:   last_tick = LAST_STOP_1P5;
        default: last_tick = LAST_STOP_2;
      endcase
    end
  end

  assign tick        = (state != IDLE) && (baud_cnt == '0);
  assign bit_end     = tick && (tick_cnt == last_tick);
  assign stop_end    = (state == STOP) && bit_end;
  // Ready in the final stop cycle lets the next frame start with no idle gap.
  assign tx.tx_ready = ((state == IDLE) || stop_end) && !clear;
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign tx_busy     = (state != IDLE);

  always_comb begin
    state_next = state;
    idx_next   = bit_idx;
    unique case (state)
      IDLE:   if (accept) state_next = START;
      START:  if (bit_end) begin
                state_next = DATA;
                idx_next   = '0;
              end
      DATA:   if (bit_end) begin
                if (bit_idx == dlen_q - 4'd1) state_next = par_en_q ? PARITY : STOP;
                else                          idx_next   = bit_idx + 4'd1;
              end
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = accept ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The line level is derived from the next state so SOUT changes together with the state register.
  always_comb begin
    line_next = 1'b1;
    unique case (state_next)
      START:   line_next = 1'b0;
      DATA:    line_next = data_q[idx_next];
      PARITY:  line_next = par_bit_q;
      default: line_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      dlen_q     <= 4'd5;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_q     <= 2'b00;
      txfinished <= 1'b0;
      sout       <= 1'b1;
    end else if (clear) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      txfinished <= 1'b0;
      sout       <= ~bc;
    end else begin
      state      <= state_next;
      bit_idx    <= idx_next;
      txfinished <= stop_end;
      sout       <= bc ? 1'b0 : line_next;
      if (accept) begin
        data_q    <= tx.tx_data;
        dlen_q    <= dlen_c;
        par_en_q  <= par_en_c;
        par_bit_q <= par_bit_c;
        stop_q    <= stop_mode;
        baud_cnt  <= div_m1;
        tick_cnt  <= '0;
      end else if (tick) begin
        baud_cnt <= div_m1;
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end else if (state != IDLE) begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: vector table, randomized frames against a waveform model,
// and hand-written back-to-back, CLEAR, break and mid-frame reset sequences.
module tb_uart_tx_engine;

  localparam int MAX_DATA_W = 9;
  localparam int DIV_W      = 16;
  localparam int OS         = 16;

  typedef struct {
    logic [MAX_DATA_W-1:0] data;
    logic [3:0]            dlen;
    logic [2:0]            par;
    logic [1:0]            stop;
    logic [DIV_W-1:0]      div;
    int                    exp_len;
    int                    exp_par;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [DIV_W-1:0] div = 16'd1;
  logic [3:0]       dlen = 4'd8;
  logic [2:0]       par_mode = 3'd0;
  logic [1:0]       stop_mode = 2'd0;
  logic             bc = 1'b0;
  logic             tx_busy, txfinished, sout;

  uart_tx_engine_if #(.MAX_DATA_W(MAX_DATA_W)) m ();

  uart_tx_engine #(.MAX_DATA_W(MAX_DATA_W), .DIV_W(DIV_W), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .div(div), .dlen(dlen),
    .par_mode(par_mode), .stop_mode(stop_mode), .bc(bc), .tx(m),
    .tx_busy(tx_busy), .txfinished(txfinished), .sout(sout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int fin_cnt = 0;

  always @(negedge clk) if (txfinished === 1'b1) fin_cnt <= fin_cnt + 1;

  logic exp_q[$];
  logic got_q[$];
  logic rdy_q[$];
  logic busy_q[$];
  logic fin_sout, fin_busy;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic bound_fail(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  function automatic int clamp_len(input logic [3:0] d);
    if (d < 5) return 5;
    if (d > MAX_DATA_W) return MAX_DATA_W;
    return int'(d);
  endfunction

  function automatic int bit_period(input logic [DIV_W-1:0] d);
    return OS * ((d == 0) ? 1 : int'(d));
  endfunction

  // Expected SOUT for every cycle of a frame, built from the frame description.
  function automatic void build_model(input vec_t v);
    int b = bit_period(v.div);
    int dl = clamp_len(v.dlen);
    int ones = 0;
    int pbit = -1;
    int stop_cycles;
    exp_q.delete();
    for (int k = 0; k < b; k++) exp_q.push_back(1'b0);
    for (int i = 0; i < dl; i++) begin
      ones += int'(v.data[i]);
      for (int k = 0; k < b; k++) exp_q.push_back(v.data[i]);
    end
    case (v.par)
      3'd1: pbit = (ones % 2 == 0) ? 1 : 0;
      3'd2: pbit = ones % 2;
      3'd3: pbit = 1;
      3'd4: pbit = 0;
      default: pbit = -1;
    endcase
    if (pbit >= 0) for (int k = 0; k < b; k++) exp_q.push_back(pbit[0]);
    stop_cycles = (v.stop == 2'd0) ? b : (v.stop == 2'd1) ? (3 * b) / 2 : 2 * b;
    for (int k = 0; k < stop_cycles; k++) exp_q.push_back(1'b1);
  endfunction

  task automatic drive_word(input vec_t v);
    div       = v.div;
    m.tx_data = v.data;
    dlen      = v.dlen;
    par_mode  = v.par;
    stop_mode = v.stop;
    m.tx_valid = 1'b1;
  endtask

  // Returns at the negedge of the first frame cycle (the cycle after accept).
  task automatic start_frame(input string name, input vec_t v);
    int w = 0;
    @(negedge clk);
    drive_word(v);
    while (m.tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (m.tx_ready !== 1'b1) bound_fail({name, "_ready_wait"});
    @(negedge clk);
  endtask

  // Samples one frame starting at the current negedge until TXFINISHED is seen.
  task automatic capture_frame(input string name, input bit chain, input vec_t nxt);
    int i = 0;
    bit done = 0;
    got_q.delete(); rdy_q.delete(); busy_q.delete();
    while (!done) begin
      if (i > 0 && txfinished === 1'b1) begin
        fin_sout = sout;
        fin_busy = tx_busy;
        m.tx_valid = 1'b0;
        done = 1;
      end else begin
        got_q.push_back(sout);
        rdy_q.push_back(m.tx_ready);
        busy_q.push_back(tx_busy);
        if (i == 0) begin
          m.tx_valid = 1'b0;
          m.tx_data  = MAX_DATA_W'($urandom);
          dlen       = 4'($urandom);
          par_mode   = 3'($urandom);
          stop_mode  = 2'($urandom);
        end
        if (chain && m.tx_ready === 1'b1) drive_word(nxt);
        i++;
        if (i > 4000) begin
          bound_fail({name, "_finish_wait"});
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic check_frame(input string name);
    int bad = -1;
    int rdy_err = 0;
    int busy_err = 0;
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0) check($sformatf("%s_sout@%0d", name, bad), got_q[bad], exp_q[bad]);
    else          check({name, "_sout"}, got_q.size() > 0 ? got_q[0] : 1'bx, 1'b0);
    for (int i = 0; i < rdy_q.size(); i++) begin
      if (rdy_q[i] !== (i == rdy_q.size() - 1)) rdy_err++;
      if (busy_q[i] !== 1'b1) busy_err++;
    end
    check({name, "_ready_errs"}, rdy_err, 0);
    check({name, "_busy_errs"}, busy_err, 0);
  endtask

  task automatic run_vector(input string name, input vec_t v);
    vec_t none;
    none = v;
    build_model(v);
    start_frame(name, v);
    capture_frame(name, 1'b0, none);
    check_frame(name);
    check({name, "_idle_after"}, fin_busy, 1'b0);
    @(negedge clk);
    check({name, "_fin_width"}, txfinished, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, va, vb;
    int fin0, errs, b, dl;

    tbl[0] = '{data: 9'h055, dlen: 4'd8,  par: 3'd0, stop: 2'd0, div: 16'd1, exp_len: 160, exp_par: -1};
    tbl[1] = '{data: 9'h041, dlen: 4'd7,  par: 3'd2, stop: 2'd2, div: 16'd3, exp_len: 528, exp_par: 0};
    tbl[2] = '{data: 9'h1A5, dlen: 4'd9,  par: 3'd3, stop: 2'd1, div: 16'd1, exp_len: 200, exp_par: 1};
    tbl[3] = '{data: 9'h01F, dlen: 4'd2,  par: 3'd1, stop: 2'd0, div: 16'd0, exp_len: 128, exp_par: 0};
    tbl[4] = '{data: 9'h100, dlen: 4'd15, par: 3'd4, stop: 2'd3, div: 16'd2, exp_len: 416, exp_par: 0};
    tbl[5] = '{data: 9'h03F, dlen: 4'd6,  par: 3'd7, stop: 2'd0, div: 16'd1, exp_len: 128, exp_par: -1};

    m.tx_valid = 1'b0;
    m.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_sout", sout, 1'b1);
    check("reset_ready", m.tx_ready, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_fin", txfinished, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_sout", sout, 1'b1);

    for (int t = 0; t < 6; t++) begin
      string nm = $sformatf("vec%0d", t);
      run_vector(nm, tbl[t]);
      check({nm, "_frame_cycles"}, got_q.size(), tbl[t].exp_len);
      if (tbl[t].exp_par >= 0) begin
        b  = bit_period(tbl[t].div);
        dl = clamp_len(tbl[t].dlen);
        if (got_q.size() > b * (1 + dl) + b / 2)
          check({nm, "_parity"}, got_q[b * (1 + dl) + b / 2], tbl[t].exp_par);
        else
          check({nm, "_parity_present"}, got_q.size(), b * (2 + dl));
      end
    end

    for (int k = 0; k < 25; k++) begin
      v.data = MAX_DATA_W'($urandom);
      v.dlen = 4'($urandom_range(0, 15));
      v.par  = 3'($urandom_range(0, 7));
      v.stop = 2'($urandom_range(0, 3));
      v.div  = DIV_W'($urandom_range(0, 2));
      v.exp_len = 0;
      v.exp_par = -1;
      run_vector($sformatf("rnd%0d", k), v);
    end

    // Two words back to back: second start bit directly follows the first stop bit.
    va = tbl[0];
    vb = '{data: 9'h0A3, dlen: 4'd8, par: 3'd2, stop: 2'd0, div: 16'd1, exp_len: 176, exp_par: 0};
    fin0 = fin_cnt;
    build_model(va);
    start_frame("b2b_a", va);
    capture_frame("b2b_a", 1'b1, vb);
    check_frame("b2b_a");
    check("b2b_no_gap_sout", fin_sout, 1'b0);
    check("b2b_busy_at_join", fin_busy, 1'b1);
    build_model(vb);
    capture_frame("b2b_b", 1'b0, vb);
    check_frame("b2b_b");
    repeat (2) @(negedge clk);
    check("b2b_fin_pulses", fin_cnt - fin0, 2);

    // CLEAR in the middle of data bit 3, with a competing TX_VALID.
    build_model(tbl[0]);
    start_frame("clr", tbl[0]);
    m.tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    fin0 = fin_cnt;
    clear = 1'b1;
    m.tx_valid = 1'b1;
    check("clr_ready_blocked", m.tx_ready, 1'b0);
    @(negedge clk);
    check("clr_sout", sout, 1'b1);
    check("clr_busy", tx_busy, 1'b0);
    check("clr_fin", txfinished, 1'b0);
    clear = 1'b0;
    m.tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    check("clr_no_fin", fin_cnt - fin0, 0);
    check("clr_stays_idle", tx_busy, 1'b0);
    run_vector("clr_next", tbl[0]);

    // Break forces the line low while framing continues; then reset mid-frame.
    build_model(tbl[0]);
    start_frame("brk", tbl[0]);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (sout !== ((i >= 20 && i < 60) ? 1'b0 : exp_q[i])) errs++;
      if (i == 0) m.tx_valid = 1'b0;
      bc = (i + 1 >= 20 && i + 1 < 60);
      @(negedge clk);
    end
    check("brk_window_errs", errs, 0);
    bc = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_hold_sout", sout, 1'b0);
    check("brk_busy", tx_busy, 1'b1);
    fin0 = fin_cnt;
    #2;
    rst_n = 1'b0;
    bc    = 1'b0;
    #1;
    check("rst_async_sout", sout, 1'b1);
    check("rst_async_ready", m.tx_ready, 1'b1);
    check("rst_async_busy", tx_busy, 1'b0);
    check("rst_async_fin", txfinished, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_no_fin", fin_cnt - fin0, 0);
    check("rst_idle_sout", sout, 1'b1);
    run_vector("rst_next", tbl[2]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
